sim_mbox_ctrl: RTL and testbench
================================

# sim_mbox_ctrl

Snooping controller for the simulation mailbox window at the CPU AHB-Lite master port (0x20007C50–0x20007C9C). It qualifies write transfers across AHB pipelining and wait states, runs the two-strike pass/fail state machines, and buffers printf characters in a FIFO drained through a valid/ready port. It also sequences the 16-entry GPR dump, publishing per-register write pulses and a completion flag. Inputs are observe-only; the block never drives the bus.

## Interface
- BASE_ADDR, 32'h20007c50, mailbox control word address; GPR window is BASE_ADDR+0x10 … BASE_ADDR+0x4C
- FIFO_DEPTH, 8, character FIFO depth, power of two, ≥2
- sysclk  in  1  core clock (one clock; all logic on rising edge)
- sysrst_b  in  1  reset, asynchronous, active-low
- haddr  in  32  snooped master HADDR
- htrans  in  2  snooped master HTRANS
- hwrite  in  1  snooped master HWRITE
- hready  in  1  snooped HREADY (slave-to-master)
- hwdata  in  32  snooped master HWDATA
- chr_vld  out  1  FIFO non-empty
- chr_data  out  8  FIFO head character
- chr_rdy  in  1  consumer accepts head
- chr_drop_cnt  out  8  characters lost to overflow, saturating
- pass_o  out  1  sticky, test passed
- fail_o  out  1  sticky, test failed
- gpr_wr_vld  out  1  one-cycle pulse per captured GPR word
- gpr_wr_idx  out  4  GPR index of pulse
- gpr_wr_data  out  32  GPR value of pulse
- gpr_mask  out  16  bit i set once GPR i captured
- gpr_done  out  1  sticky, dump complete

## Operation
- Address phase accepted when htrans==2'b10 (NONSEQ) && hwrite && hready; captures haddr into pend_addr, sets pend. SEQ/IDLE/BUSY and reads ignored.
- Data phase completes on first cycle with pend && hready; hwdata sampled then. Wait states (hready=0) hold pend and pend_addr unchanged.
- Back-to-back: a new address phase accepted in the same cycle that completes the previous data phase reloads pend_addr and keeps pend=1; no transfer lost.
- Decode at data-phase completion, pend_addr == BASE_ADDR:
  - hwdata==32'h1001: fail FSM; hwdata==32'h2002: pass FSM; any other value: push hwdata[7:0] to FIFO.
- Pass and fail FSMs, independent: IDLE → ARMED on first marker; ARMED → HIT on second marker (any number of intervening writes). HIT sets pass_o/fail_o. Once pass_o or fail_o is set, both FSMs freeze; further markers are ignored; character pushes continue.
- GPR window: pend_addr in [BASE_ADDR+0x10, BASE_ADDR+0x4C] with pend_addr[1:0]==0: idx=(pend_addr−BASE_ADDR−0x10)>>2 (4 bits); pulse gpr_wr_vld with idx/data, set gpr_mask[idx]. Address BASE_ADDR+0x4C additionally sets gpr_done. Misaligned addresses in window ignored. Rewrites re-pulse; mask stays set.
- FIFO: chr_vld = !empty, chr_data = head; pop on chr_vld && chr_rdy. Push when full: dropped unless a pop occurs the same cycle (then both succeed, count unchanged). Each drop increments chr_drop_cnt, saturating at 8'hFF. Push and pop on empty FIFO: push only (no bypass). Pointers wrap modulo FIFO_DEPTH with extra wrap bit for full/empty.
- Reset (any time, including mid-transfer): pend, FSMs, FIFO, mask, counters cleared; in-flight data phase discarded.

## Timing
- Reset values: chr_vld 0, chr_data 0, chr_drop_cnt 0, pass_o 0, fail_o 0, gpr_wr_vld 0, gpr_wr_idx 0, gpr_wr_data 0, gpr_mask 0, gpr_done 0.
- Address phase edge N, zero wait states: data sampled at edge N+1; registered outputs (pass_o/fail_o, gpr_* , FIFO write) visible after edge N+1. Each wait state adds one cycle.
- chr_vld rises the cycle after the push edge into an empty FIFO; chr_data stable while chr_vld && !chr_rdy.
- Sustained throughput: one mailbox write per cycle, one pop per cycle.
- gpr_wr_vld exactly one cycle per qualifying data phase; gpr_done and gpr_mask bit update same edge as the final pulse.

## Test plan
- Write 0x41,0x42,0x43 to 0x20007C50 back-to-back, chr_rdy=1 -> chr_data 0x41,0x42,0x43 in order, one per cycle, chr_drop_cnt=0.
- Two writes of 0x2002 separated by a 0x0A write, with 2 wait states on the second -> pass_o rises one edge after final data phase; fail_o stays 0; 0x0A appears on chr_data.
- Single 0x1001 then 0x2002 twice -> pass_o=1, fail_o=0; subsequent 0x1001 pair -> fail_o remains 0.
- chr_rdy=0, write 10 characters with FIFO_DEPTH=8 -> 8 retained, chr_drop_cnt=2; full FIFO push with chr_rdy=1 same cycle -> no drop.
- Write 0x100+i to 0x20007C60+4i for i=0..15, plus misaligned write to 0x20007C62 -> 16 gpr_wr_vld pulses with idx i, data 0x100+i; gpr_mask=16'hFFFF; gpr_done rises with idx 15; misaligned write produces no pulse.
- Assert sysrst_b low during a pending data phase and with FIFO holding 3 chars -> all outputs at reset values immediately; no character or pulse after release.

Source files
------------

// File: rtl/sim_mbox_ctrl_if.sv
// Snooped AHB-Lite write-side signals plus the character drain port of the
// simulation mailbox controller. The master side is the environment (bus
// observer and character consumer); the slave side is the controller.
interface sim_mbox_ctrl_if;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic        hready;
  logic [31:0] hwdata;
  logic        chr_vld;
  logic [7:0]  chr_data;
  logic        chr_rdy;

  modport master (
    output haddr, htrans, hwrite, hready, hwdata, chr_rdy,
    input  chr_vld, chr_data
  );

  modport slave (
    input  haddr, htrans, hwrite, hready, hwdata, chr_rdy,
    output chr_vld, chr_data
  );
endinterface

// File: rtl/sim_mbox_ctrl.sv
// Simulation mailbox snooper: qualifies AHB-Lite writes into the mailbox
// window, runs the two-strike pass/fail detectors, buffers printf characters
// in a small FIFO and publishes the GPR dump as write pulses plus a mask.
// Observe-only: nothing here drives the bus.
module sim_mbox_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h20007c50,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic            sysclk,
  input  logic            sysrst_b,
  sim_mbox_ctrl_if.slave  bus,
  output logic [7:0]      chr_drop_cnt,
  output logic            pass_o,
  output logic            fail_o,
  output logic            gpr_wr_vld,
  output logic [3:0]      gpr_wr_idx,
  output logic [31:0]     gpr_wr_data,
  output logic [15:0]     gpr_mask,
  output logic            gpr_done
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {MK_IDLE, MK_ARMED, MK_HIT} mk_state_t;

  // Address/data phase tracking
  logic        pend;
  logic [31:0] pend_addr;
  logic        addr_ok;
  logic        data_done;

  assign addr_ok   = (bus.htrans == 2'b10) && bus.hwrite && bus.hready;
  assign data_done = pend && bus.hready;

  // Decode of the completing data phase
  logic [31:0] offset;
  logic        is_ctrl;
  logic        is_pass_mk;
  logic        is_fail_mk;
  logic        gpr_hit;
  logic [3:0]  gpr_idx;

  assign offset     = pend_addr - BASE_ADDR;
  assign is_ctrl    = (offset == 32'h0);
  assign is_pass_mk = (bus.hwdata == 32'h2002);
  assign is_fail_mk = (bus.hwdata == 32'h1001);
  assign gpr_hit    = data_done && (offset >= 32'h10) && (offset <= 32'h4c) &&
                      (offset[1:0] == 2'b00);
  // Offsets 0x10..0x4C map to word indices 4..19; subtract 4 for 0..15.
  assign gpr_idx    = 4'(offset[6:2] - 5'd4);

  // Track the outstanding data phase; a new accepted address wins over completion
  always_ff @(posedge sysclk or negedge sysrst_b) begin
    if (!sysrst_b) begin
      pend      <= 1'b0;
      pend_addr <= 32'h0;
    end else if (addr_ok) begin
      pend      <= 1'b1;
      pend_addr <= bus.haddr;
    end else if (data_done) begin
      pend      <= 1'b0;
    end
  end

  // Pass/fail marker detectors
  mk_state_t pass_state, pass_next;
  mk_state_t fail_state, fail_next;
  logic      frozen;
  logic      ctrl_wr;

  assign frozen  = (pass_state == MK_HIT) || (fail_state == MK_HIT);
  assign ctrl_wr = data_done && is_ctrl;
  assign pass_o  = (pass_state == MK_HIT);
  assign fail_o  = (fail_state == MK_HIT);

  // Detector state registers
  always_ff @(posedge sysclk or negedge sysrst_b) begin
    if (!sysrst_b) begin
      pass_state <= MK_IDLE;
      fail_state <= MK_IDLE;
    end else begin
      pass_state <= pass_next;
      fail_state <= fail_next;
    end
  end

  // Advance a detector on its own marker; everything freezes once one hits
  always_comb begin
    pass_next = pass_state;
    fail_next = fail_state;
    if (ctrl_wr && !frozen) begin
      if (is_pass_mk) begin
        case (pass_state)
          MK_IDLE:  pass_next = MK_ARMED;
          MK_ARMED: pass_next = MK_HIT;
          default:  pass_next = pass_state;
        endcase
      end
      if (is_fail_mk) begin
        case (fail_state)
          MK_IDLE:  fail_next = MK_ARMED;
          MK_ARMED: fail_next = MK_HIT;
          default:  fail_next = fail_state;
        endcase
      end
    end
  end

  // Character FIFO; pointers carry one extra wrap bit to split full from empty
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        push_req;
  logic        push;
  logic        pop;
  logic        drop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_req = ctrl_wr && !is_pass_mk && !is_fail_mk;
  assign pop      = !empty && bus.chr_rdy;
  // A pop in the same cycle frees the slot, so a push into a full FIFO survives
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  assign bus.chr_vld  = !empty;
  assign bus.chr_data = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

  // Character storage write
  always_ff @(posedge sysclk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= bus.hwdata[7:0];
    end
  end

  // FIFO pointers and saturating overflow counter
  always_ff @(posedge sysclk or negedge sysrst_b) begin
    if (!sysrst_b) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      chr_drop_cnt <= 8'h00;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (drop && (chr_drop_cnt != 8'hff)) begin
        chr_drop_cnt <= chr_drop_cnt + 8'd1;
      end
    end
  end

  // GPR dump capture: one pulse per aligned window write, sticky mask and done
  always_ff @(posedge sysclk or negedge sysrst_b) begin
    if (!sysrst_b) begin
      gpr_wr_vld  <= 1'b0;
      gpr_wr_idx  <= 4'h0;
      gpr_wr_data <= 32'h0;
      gpr_mask    <= 16'h0000;
      gpr_done    <= 1'b0;
    end else begin
      gpr_wr_vld <= gpr_hit;
      if (gpr_hit) begin
        gpr_wr_idx            <= gpr_idx;
        gpr_wr_data           <= bus.hwdata;
        gpr_mask[gpr_idx]     <= 1'b1;
        if (offset == 32'h4c) begin
          gpr_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sim_mbox_ctrl.sv
// Self-checking bench for sim_mbox_ctrl: directed scenarios plus randomized
// mailbox traffic, compared every cycle against a transaction-level model.
module tb_sim_mbox_ctrl;
  localparam logic [31:0] BASE  = 32'h20007c50;
  localparam int          DEPTH = 8;

  logic        sysclk   = 1'b0;
  logic        sysrst_b = 1'b1;
  logic [7:0]  chr_drop_cnt;
  logic        pass_o;
  logic        fail_o;
  logic        gpr_wr_vld;
  logic [3:0]  gpr_wr_idx;
  logic [31:0] gpr_wr_data;
  logic [15:0] gpr_mask;
  logic        gpr_done;

  sim_mbox_ctrl_if bus();

  sim_mbox_ctrl #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .sysclk       (sysclk),
    .sysrst_b     (sysrst_b),
    .bus          (bus),
    .chr_drop_cnt (chr_drop_cnt),
    .pass_o       (pass_o),
    .fail_o       (fail_o),
    .gpr_wr_vld   (gpr_wr_vld),
    .gpr_wr_idx   (gpr_wr_idx),
    .gpr_wr_data  (gpr_wr_data),
    .gpr_mask     (gpr_mask),
    .gpr_done     (gpr_done)
  );

  always #5 sysclk = ~sysclk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0]  q[$];
  int          drop_m;
  int          pass_cnt, fail_cnt;
  bit          pass_m, fail_m;
  bit          gv_m;
  logic [3:0]  gi_m;
  logic [31:0] gd_m;
  logic [15:0] mask_m;
  bit          done_m;
  bit          mp;
  logic [31:0] ma;

  // Driver state: data phase still owed by the bus master
  bit          out_v;
  logic [31:0] out_d;
  int          out_w;
  int          rdy_mode;
  int          pulses;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    drop_m = 0; pass_cnt = 0; fail_cnt = 0; pass_m = 0; fail_m = 0;
    gv_m = 0; gi_m = 4'h0; gd_m = 32'h0; mask_m = 16'h0; done_m = 0;
    mp = 0; ma = 32'h0;
  endtask

  // One clock edge of the specified behaviour, using the inputs now on the bus
  task automatic model_edge();
    bit          pop, full, complete, push_req;
    logic [31:0] d;
    if (!sysrst_b) begin
      model_reset();
      return;
    end
    d        = bus.hwdata;
    pop      = (q.size() > 0) && bus.chr_rdy;
    full     = (q.size() == DEPTH);
    complete = mp && bus.hready;
    push_req = 0;
    gv_m     = 0;
    if (complete) begin
      if (ma == BASE) begin
        if (d == 32'h2002 || d == 32'h1001) begin
          if (!(pass_m || fail_m)) begin
            if (d == 32'h2002) pass_cnt++;
            else fail_cnt++;
          end
        end else begin
          push_req = 1;
        end
      end else if (ma >= BASE + 32'd16 && ma <= BASE + 32'd76 && ma[1:0] == 2'b00) begin
        gv_m = 1;
        gi_m = 4'((ma - BASE - 32'd16) >> 2);
        gd_m = d;
        mask_m[gi_m] = 1'b1;
        if (ma == BASE + 32'd76) done_m = 1;
      end
    end
    pass_m = (pass_cnt >= 2);
    fail_m = (fail_cnt >= 2);
    if (pop) void'(q.pop_front());
    if (push_req) begin
      if (!full || pop) q.push_back(d[7:0]);
      else if (drop_m < 255) drop_m++;
    end
    if (bus.htrans == 2'b10 && bus.hwrite && bus.hready) begin
      mp = 1; ma = bus.haddr;
    end else if (complete) begin
      mp = 0;
    end
  endtask

  task automatic check_outputs();
    check_val("chr_vld", 32'(bus.chr_vld), 32'(q.size() > 0));
    check_val("chr_data", 32'(bus.chr_data), 32'((q.size() > 0) ? q[0] : 8'h00));
    check_val("chr_drop_cnt", 32'(chr_drop_cnt), 32'(drop_m));
    check_val("pass_o", 32'(pass_o), 32'(pass_m));
    check_val("fail_o", 32'(fail_o), 32'(fail_m));
    check_val("gpr_wr_vld", 32'(gpr_wr_vld), 32'(gv_m));
    if (gv_m) begin
      check_val("gpr_wr_idx", 32'(gpr_wr_idx), 32'(gi_m));
      check_val("gpr_wr_data", gpr_wr_data, gd_m);
      pulses++;
    end
    check_val("gpr_mask", 32'(gpr_mask), 32'(mask_m));
    check_val("gpr_done", 32'(gpr_done), 32'(done_m));
  endtask

  // Entered just after a rising edge with inputs already driven
  task automatic cycle();
    case (rdy_mode)
      0:       bus.chr_rdy = 1'b0;
      1:       bus.chr_rdy = 1'b1;
      default: bus.chr_rdy = 1'($urandom_range(0, 1));
    endcase
    @(negedge sysclk);
    check_outputs();
    model_edge();
    @(posedge sysclk);
    #1;
  endtask

  // Issue a write address phase, finishing the previous data phase alongside
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input int w);
    int n;
    n = out_v ? out_w : 0;
    repeat (n) begin
      bus.htrans = 2'b10; bus.haddr = a; bus.hwrite = 1'b1;
      bus.hready = 1'b0;  bus.hwdata = $urandom;
      cycle();
    end
    bus.htrans = 2'b10; bus.haddr = a; bus.hwrite = 1'b1; bus.hready = 1'b1;
    bus.hwdata = out_v ? out_d : $urandom;
    cycle();
    out_v = 1; out_d = d; out_w = w;
  endtask

  // A cycle with no accepted write; noise transfers that must be ignored
  task automatic bus_idle();
    int n;
    n = out_v ? out_w : 0;
    repeat (n) begin
      bus.htrans = 2'b00; bus.hready = 1'b0; bus.hwdata = $urandom;
      cycle();
    end
    bus.haddr = BASE; bus.hready = 1'b1;
    case ($urandom_range(0, 3))
      0: begin bus.htrans = 2'b00; bus.hwrite = 1'b1; end
      1: begin bus.htrans = 2'b01; bus.hwrite = 1'b1; end
      2: begin bus.htrans = 2'b11; bus.hwrite = 1'b1; end
      default: begin bus.htrans = 2'b10; bus.hwrite = 1'b0; end
    endcase
    bus.hwdata = out_v ? out_d : 32'h0000_0058;
    cycle();
    out_v = 0;
  endtask

  task automatic do_reset();
    bus.htrans = 2'b00; bus.hready = 1'b1; bus.hwrite = 1'b0;
    sysrst_b = 1'b0;
    #1;
    model_reset();
    out_v = 0;
    check_outputs();
    cycle();
    cycle();
    sysrst_b = 1'b1;
  endtask

  initial begin
    logic [31:0] a, d;
    int          r;
    bus.haddr = 32'h0; bus.htrans = 2'b00; bus.hwrite = 1'b0;
    bus.hready = 1'b1; bus.hwdata = 32'h0; bus.chr_rdy = 1'b0;
    out_v = 0; out_d = 0; out_w = 0; rdy_mode = 1; pulses = 0;
    model_reset();
    #2;
    do_reset();

    // Three characters back-to-back, drained one per cycle
    rdy_mode = 1;
    bus_write(BASE, 32'h41, 0);
    bus_write(BASE, 32'h42, 0);
    bus_write(BASE, 32'h43, 0);
    repeat (4) bus_idle();
    check_val("chars_drop", 32'(chr_drop_cnt), 32'd0);

    // Pass pair around a character, the second marker with two wait states
    bus_write(BASE, 32'h2002, 0);
    bus_write(BASE, 32'h0a, 0);
    bus_write(BASE, 32'h2002, 2);
    repeat (3) bus_idle();
    check_val("pass_after_pair", 32'(pass_o), 32'd1);
    check_val("fail_after_pair", 32'(fail_o), 32'd0);

    // Lone fail marker, pass pair, then a late fail pair that must be ignored
    do_reset();
    bus_write(BASE, 32'h1001, 0);
    bus_write(BASE, 32'h2002, 1);
    bus_write(BASE, 32'h2002, 0);
    bus_write(BASE, 32'h1001, 0);
    bus_write(BASE, 32'h1001, 0);
    repeat (3) bus_idle();
    check_val("pass_frozen", 32'(pass_o), 32'd1);
    check_val("fail_frozen", 32'(fail_o), 32'd0);

    // Overflow: ten characters into eight slots, then push while full and popping
    do_reset();
    rdy_mode = 0;
    for (int i = 0; i < 10; i++) bus_write(BASE, 32'h30 + 32'(i), 0);
    bus_idle();
    check_val("drop_after_10", 32'(chr_drop_cnt), 32'd2);
    rdy_mode = 1;
    bus_write(BASE, 32'h5a, 0);
    bus_idle();
    check_val("drop_full_pop", 32'(chr_drop_cnt), 32'd2);
    repeat (10) bus_idle();

    // GPR dump with a misaligned write in the window
    do_reset();
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      bus_write(BASE + 32'h10 + 32'(4 * i), 32'h100 + 32'(i), $urandom_range(0, 1));
      if (i == 7) bus_write(BASE + 32'h12, 32'hdead, 0);
    end
    repeat (3) bus_idle();
    check_val("gpr_pulses", 32'(pulses), 32'd16);
    check_val("gpr_mask_full", 32'(gpr_mask), 32'h0000ffff);
    check_val("gpr_done_set", 32'(gpr_done), 32'd1);

    // Reset mid data phase with three characters held
    do_reset();
    rdy_mode = 0;
    for (int i = 0; i < 3; i++) bus_write(BASE, 32'h61 + 32'(i), 0);
    bus_write(BASE, 32'h58, 3);
    bus.htrans = 2'b00; bus.hready = 1'b0; bus.hwdata = 32'h58;
    cycle();
    check_val("held_before_rst", 32'(bus.chr_vld), 32'd1);
    #2;
    sysrst_b = 1'b0;
    #1;
    model_reset();
    out_v = 0;
    check_outputs();
    check_val("vld_in_rst", 32'(bus.chr_vld), 32'd0);
    bus.hready = 1'b1;
    @(posedge sysclk);
    #1;
    cycle();
    sysrst_b = 1'b1;
    rdy_mode = 1;
    repeat (4) begin
      bus.htrans = 2'b00; bus.hready = 1'b1; bus.hwdata = 32'h58;
      cycle();
    end

    // Randomized traffic across the window, markers and foreign addresses
    for (int round = 0; round < 4; round++) begin
      do_reset();
      rdy_mode = 2;
      repeat (80) begin
        r = $urandom_range(0, 9);
        d = $urandom;
        if (r <= 3) begin
          a = BASE;
          case ($urandom_range(0, 9))
            0, 1:    d = 32'h2002;
            2, 3:    d = 32'h1001;
            default: d = $urandom;
          endcase
        end else if (r <= 6) a = BASE + 32'h10 + 32'(4 * $urandom_range(0, 15));
        else if (r == 7)     a = BASE + 32'h10 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
        else                 a = ($urandom_range(0, 1) != 0) ? BASE + 32'h4 : BASE + 32'h50;
        if (r == 9) bus_idle();
        else bus_write(a, d, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
      end
      repeat (12) bus_idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
